// File: rtl/interval_activity_detector.sv
// Per-interval peak-to-peak activity detector with on/off hysteresis thresholds.
// Define HANGOVER_EN to hold activity for HANG_LEN consecutive low intervals before dropping it.
module interval_activity_detector #(
    parameter int IDX_W    = 16,
    parameter int HANG_LEN = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         thr_on,
    input  logic [31:0]         thr_off,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [31:0]  in_min,
    input  logic signed [31:0]  in_max,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [32:0]         out_p2p,
    output logic                out_active,
    output logic [IDX_W-1:0]    out_index,
    output logic [IDX_W-1:0]    active_count,
    output logic                err,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACCEPT = 3'd1,
        CALC   = 3'd2,
        EMIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t             state_q;
    logic [31:0]        thr_on_q, thr_off_q;
    logic signed [31:0] min_q, max_q;
    logic               last_q;
    logic [7:0]         hang_q;
    logic               in_ready_q, out_valid_q, active_q, err_q, done_q;
    logic [32:0]        p2p_q;
    logic [IDX_W-1:0]   index_q, count_q;

    logic               neg_d;
    logic [32:0]        diff_d, p2p_d;
    logic               active_d;
    logic [7:0]         hang_d;
    logic [IDX_W-1:0]   count_d;

    // 33-bit difference of sign-extended operands cannot overflow
    always_comb begin
        diff_d = {max_q[31], max_q} - {min_q[31], min_q};
        neg_d  = (min_q > max_q);
        p2p_d  = neg_d ? 33'd0 : diff_d;
    end

    always_comb begin
        active_d = active_q;
        hang_d   = hang_q;
        if (!active_q) begin
            if (p2p_d >= {1'b0, thr_on_q}) begin
                active_d = 1'b1;
                hang_d   = 8'(HANG_LEN);
            end
        end else if (p2p_d >= {1'b0, thr_off_q}) begin
            hang_d = 8'(HANG_LEN);
        end else begin
`ifdef HANGOVER_EN
            if (hang_q <= 8'd1) begin
                active_d = 1'b0;
                hang_d   = 8'd0;
            end else begin
                hang_d = hang_q - 8'd1;
            end
`else
            active_d = 1'b0;
`endif
        end
    end

    always_comb begin
        count_d = count_q;
        if (active_d && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            thr_on_q    <= '0;
            thr_off_q   <= '0;
            min_q       <= '0;
            max_q       <= '0;
            last_q      <= 1'b0;
            hang_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            active_q    <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            p2p_q       <= '0;
            index_q     <= '0;
            count_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        thr_on_q   <= thr_on;
                        thr_off_q  <= thr_off;
                        index_q    <= '0;
                        count_q    <= '0;
                        err_q      <= 1'b0;
                        active_q   <= 1'b0;
                        hang_q     <= '0;
                        in_ready_q <= 1'b1;
                        state_q    <= ACCEPT;
                    end
                end
                ACCEPT: begin
                    if (in_valid) begin
                        min_q      <= in_min;
                        max_q      <= in_max;
                        last_q     <= in_last;
                        in_ready_q <= 1'b0;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    p2p_q       <= p2p_d;
                    active_q    <= active_d;
                    hang_q      <= hang_d;
                    count_q     <= count_d;
                    if (neg_d)
                        err_q <= 1'b1;
                    out_valid_q <= 1'b1;
                    state_q     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            index_q    <= index_q + 1'b1;
                            in_ready_q <= 1'b1;
                            state_q    <= ACCEPT;
                        end
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign out_p2p      = p2p_q;
    assign out_active   = active_q;
    assign out_index    = index_q;
    assign active_count = count_q;
    assign err          = err_q;
    assign done         = done_q;

endmodule

// File: tb/tb_interval_activity_detector.sv
// Randomized and directed bench for interval_activity_detector against a behavioural model.
// Build with or without HANGOVER_EN to match the design under test.
module tb_interval_activity_detector;

    localparam int IDX_W = 16;
    localparam int HANG  = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        thr_on = '0, thr_off = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_min = '0, in_max = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [32:0]        out_p2p;
    logic               out_active;
    logic [IDX_W-1:0]   out_index, active_count;
    logic               err, done;

    interval_activity_detector #(.IDX_W(IDX_W), .HANG_LEN(HANG)) dut (
        .clk(clk), .reset(reset), .start(start), .thr_on(thr_on), .thr_off(thr_off),
        .in_valid(in_valid), .in_ready(in_ready), .in_min(in_min), .in_max(in_max),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_p2p(out_p2p),
        .out_active(out_active), .out_index(out_index), .active_count(active_count),
        .err(err), .done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    logic signed [31:0] q_min[$];
    logic signed [31:0] q_max[$];

    // Model state for the current run
    bit  m_active;
    int  m_lows;
    int  m_count;
    bit  m_err;

    function automatic longint ref_p2p(input logic signed [31:0] mn, input logic signed [31:0] mx);
        longint d;
        d = longint'(mx) - longint'(mn);
        return (d < 0) ? 64'sd0 : d;
    endfunction

    task automatic model_step(input longint p, input logic [31:0] on, input logic [31:0] off);
        if (!m_active) begin
            if (p >= longint'(on)) begin
                m_active = 1'b1;
                m_lows   = 0;
            end
        end else if (p >= longint'(off)) begin
            m_lows = 0;
        end else begin
            m_lows++;
`ifdef HANGOVER_EN
            if (m_lows >= HANG) m_active = 1'b0;
`else
            m_active = 1'b0;
`endif
        end
        if (m_active) m_count++;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_p2p"}, 64'(out_p2p), 64'd0);
        check({tag, "_active"}, 64'(out_active), 64'd0);
        check({tag, "_index"}, 64'(out_index), 64'd0);
        check({tag, "_count"}, 64'(active_count), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    // emit_stall < 0 selects a random EMIT stall of 0..3 cycles
    task automatic run_seq(input logic [31:0] on, input logic [31:0] off,
                           input int emit_stall, input bit poke_start);
        int n;
        int w;
        int stall;
        longint p;
        n = q_min.size();
        m_active = 1'b0; m_lows = 0; m_count = 0; m_err = 1'b0;
        @(negedge clk);
        start = 1'b1; thr_on = on; thr_off = off;
        @(negedge clk);
        start = 1'b0; thr_on = $urandom; thr_off = $urandom;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1; in_min = q_min[i]; in_max = q_max[i]; in_last = (i == n - 1);
            w = 0;
            while (!in_ready && w < 50) begin @(negedge clk); w++; end
            if (!in_ready) begin
                check("in_ready_timeout", 64'(in_ready), 64'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            in_valid = 1'b0;
            check("in_ready_drop", 64'(in_ready), 64'd0);
            p = ref_p2p(q_min[i], q_max[i]);
            if (q_min[i] > q_max[i]) m_err = 1'b1;
            model_step(p, on, off);
            w = 0;
            while (!out_valid && w < 50) begin @(negedge clk); w++; end
            if (!out_valid) begin
                check("out_valid_timeout", 64'(out_valid), 64'd1);
                return;
            end
            if (poke_start) begin
                start = 1'b1; thr_on = 32'd0; thr_off = 32'd0;
                @(negedge clk);
                start = 1'b0;
            end
            stall = (emit_stall < 0) ? int'($urandom_range(0, 3)) : emit_stall;
            for (int s = 0; s <= stall; s++) begin
                if (s > 0) @(negedge clk);
                check("out_valid", 64'(out_valid), 64'd1);
                check("p2p", 64'(out_p2p), 64'(p));
                check("active", 64'(out_active), 64'(m_active));
                check("index", 64'(out_index), 64'(i));
                check("count", 64'(active_count), 64'(m_count));
                check("err", 64'(err), 64'(m_err));
                check("emit_in_ready", 64'(in_ready), 64'd0);
            end
            $display("interval %0d: min=%0d max=%0d p2p=%0d active=%0d count=%0d err=%0d",
                     i, q_min[i], q_max[i], out_p2p, out_active, active_count, err);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("single_xfer", 64'(out_valid), 64'd0);
            if (i == n - 1) begin
                check("done_pulse", 64'(done), 64'd1);
                @(negedge clk);
                check("done_clear", 64'(done), 64'd0);
                check("idle_in_ready", 64'(in_ready), 64'd0);
            end else begin
                check("done_early", 64'(done), 64'd0);
            end
        end
    endtask

    task automatic push(input logic signed [31:0] mn, input logic signed [31:0] mx);
        q_min.push_back(mn);
        q_max.push_back(mx);
    endtask

    initial begin
        int np;
        int a, b;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b1;

        // Reference run with known hysteresis behaviour
        q_min.delete(); q_max.delete();
        push(-100, 100); push(-600, 600); push(-300, 300);
        run_seq(32'd1000, 32'd500, -1, 1'b0);
        check("ref_count", 64'(active_count), 64'd2);
        check("ref_last_p2p", 64'(out_p2p), 64'd600);

        q_min.delete(); q_max.delete();
`ifdef HANGOVER_EN
        push(-600, 600); push(-200, 200); push(-200, 200); push(-200, 200);
        run_seq(32'd1000, 32'd500, -1, 1'b0);
        check("hang_final_active", 64'(out_active), 64'd0);
        check("hang_final_count", 64'(active_count), 64'd2);
`else
        push(-600, 600); push(-200, 200); push(-600, 600);
        run_seq(32'd1000, 32'd500, -1, 1'b0);
        check("nohang_final_active", 64'(out_active), 64'd1);
        check("nohang_final_count", 64'(active_count), 64'd2);
`endif

        // Extreme range and inverted pair
        q_min.delete(); q_max.delete();
        push(32'sh80000000, 32'sh7FFFFFFF); push(10, -10); push(0, 5);
        run_seq(32'd100, 32'd50, -1, 1'b0);
        check("err_held", 64'(err), 64'd1);
        check("edge_last_p2p", 64'(out_p2p), 64'd5);

        // Downstream stall of five cycles
        q_min.delete(); q_max.delete();
        push(-7, 9);
        run_seq(32'd10, 32'd5, 5, 1'b0);

        // Start pulses during a run are ignored
        q_min.delete(); q_max.delete();
        push(-50, 50); push(-10, 10); push(-80, 80);
        run_seq(32'd90, 32'd30, -1, 1'b1);
        check("poke_index", 64'(out_index), 64'd2);

        // Reset while in CALC
        @(negedge clk);
        start = 1'b1; thr_on = 32'd10; thr_off = 32'd5;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_min = -600; in_max = 600; in_last = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_idle_outputs("midrun_reset");
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_reset_done", 64'(done), 64'd0);
            check("post_reset_in_ready", 64'(in_ready), 64'd0);
            check("post_reset_out_valid", 64'(out_valid), 64'd0);
        end
        q_min.delete(); q_max.delete();
        push(-3, 3); push(-40, 40);
        run_seq(32'd50, 32'd10, -1, 1'b0);

        // Randomized runs
        for (int r = 0; r < 20; r++) begin
            logic [31:0] on, off;
            q_min.delete(); q_max.delete();
            np = int'($urandom_range(1, 6));
            for (int k = 0; k < np; k++) begin
                a = int'($urandom_range(0, 4000)) - 2000;
                b = int'($urandom_range(0, 4000)) - 2000;
                if (a > b && $urandom_range(0, 3) != 0) push(b, a);
                else push(a, b);
            end
            on  = $urandom_range(0, 3000);
            off = $urandom_range(0, on);
            run_seq(on, off, -1, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
